// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed radix-4-lane FFT output into natural bin order via ping-pong banks.
// Optional macro REORDER_SYNC_EN adds an in_sof input that realigns the write counter.
module fft_out_reorder #(
    parameter int unsigned NBITS_out = 19,
    parameter int unsigned N         = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NBITS_out-1:0] fftIn0_up,
    input  logic [2*NBITS_out-1:0] fftIn0_down,
    input  logic [2*NBITS_out-1:0] fftIn1_up,
    input  logic [2*NBITS_out-1:0] fftIn1_down,
    input  logic                   in_valid,
`ifdef REORDER_SYNC_EN
    input  logic                   in_sof,
`endif
    output logic [2*NBITS_out-1:0] fftOut0_up,
    output logic [2*NBITS_out-1:0] fftOut0_down,
    output logic [2*NBITS_out-1:0] fftOut1_up,
    output logic [2*NBITS_out-1:0] fftOut1_down,
    output logic                   out_valid,
    output logic                   out_sof
);

    localparam int unsigned D = N / 4;
    localparam int unsigned B = $clog2(D);
    localparam int unsigned W = 2 * NBITS_out;
    localparam logic [B-1:0] LastCnt = B'(D - 1);

    typedef enum logic {RdIdle, RdBusy} rdState_t;

    // Bank select is the MSB of the word index.
    logic [W-1:0] mem [4][2*D];
    logic [W-1:0] laneIn [4];
    logic [W-1:0] outLane [4];

    logic [B-1:0] wcnt, wAddr, rcnt;
    logic         wsel, rsel, frameReady, readyBank, syncBeat;
    rdState_t     rdState;

    assign laneIn[0] = fftIn0_up;
    assign laneIn[1] = fftIn0_down;
    assign laneIn[2] = fftIn1_up;
    assign laneIn[3] = fftIn1_down;

`ifdef REORDER_SYNC_EN
    assign syncBeat = in_valid & in_sof;
`else
    assign syncBeat = 1'b0;
`endif

    always_comb begin
        wAddr = '0;
        for (int i = 0; i < int'(B); i++) begin
            wAddr[i] = wcnt[int'(B) - 1 - i];
        end
        if (syncBeat) begin
            wAddr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt       <= '0;
            wsel       <= 1'b0;
            frameReady <= 1'b0;
            readyBank  <= 1'b0;
        end else begin
            frameReady <= 1'b0;
            if (syncBeat) begin
                // Partial frame is abandoned; the sof beat itself is k=0.
                wcnt <= B'(1);
            end else if (in_valid) begin
                wcnt <= wcnt + B'(1);
                if (wcnt == LastCnt) begin
                    wsel       <= ~wsel;
                    frameReady <= 1'b1;
                    readyBank  <= wsel;
                end
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int l = 0; l < 4; l++) begin
                mem[l][{wsel, wAddr}] <= laneIn[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdState   <= RdIdle;
            rcnt      <= '0;
            rsel      <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            for (int l = 0; l < 4; l++) begin
                outLane[l] <= '0;
            end
        end else begin
            out_valid <= (rdState == RdBusy);
            out_sof   <= (rdState == RdBusy) && (rcnt == '0);
            if (rdState == RdBusy) begin
                for (int l = 0; l < 4; l++) begin
                    outLane[l] <= mem[l][{rsel, rcnt}];
                end
            end
            case (rdState)
                RdIdle: begin
                    if (frameReady) begin
                        rdState <= RdBusy;
                        rcnt    <= '0;
                        rsel    <= readyBank;
                    end
                end
                RdBusy: begin
                    if (rcnt == LastCnt) begin
                        rcnt <= '0;
                        // A frame completing on the last read beat chains without a bubble.
                        if (frameReady) begin
                            rsel <= readyBank;
                        end else begin
                            rdState <= RdIdle;
                        end
                    end else begin
                        rcnt <= rcnt + B'(1);
                    end
                end
                default: rdState <= RdIdle;
            endcase
        end
    end

    assign fftOut0_up   = outLane[0];
    assign fftOut0_down = outLane[1];
    assign fftOut1_up   = outLane[2];
    assign fftOut1_down = outLane[3];

endmodule
